// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_pkg
//  Description : Shared definitions for the accelerator datapath blocks.
//                Holds the kernel geometry, default widths, the weight loader
//                state encoding and a helper that turns a channel count into
//                a weight word count.
//  Revision    : 1.0  - initial release
// ============================================================================
package acc_pkg;

    // Words per re-parameterised 3x3 kernel
    localparam int KERNEL_WORDS = 9;

    // Default widths
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 20;
    localparam int BUF_AW_DEF = 12;
    localparam int CH_W       = 8;
    localparam int CNT_W      = 12;   // 255*9 = 2295 fits in 12 bits
    localparam int OFF_W      = 20;   // 255*2295 = 585225 fits in 20 bits

    typedef enum logic [2:0] {
        WL_IDLE  = 3'd0,
        WL_CALC  = 3'd1,
        WL_ISSUE = 3'd2,
        WL_DRAIN = 3'd3,
        WL_DONE  = 3'd4
    } wl_state_t;

    // Number of weight words for a given input channel count
    function automatic logic [CNT_W-1:0] word_count(input logic [CH_W-1:0] ch);
        return CNT_W'(ch) * CNT_W'(KERNEL_WORDS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wl_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : wl_addr_gen
//  Description : Read address generator for the weight loader. Latches the
//                weight region base and output channel index at start,
//                computes the per-channel offset with a registered multiply
//                during the calc cycle, and forms
//                mem_addr = base + offset + issue_cnt (modulo 2^ADDR_W).
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                load            - accepted start; captures base / channel
//                wt_base         - weight region base address
//                out_ch_cnt      - current output channel index
//                calc_en         - calc cycle; registers the offset product
//                n_words         - latched word count per output channel
//                issue_cnt       - number of grants so far
//                mem_addr        - read address
//  Revision    : 1.0  - initial release
// ============================================================================
module wl_addr_gen
    import acc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [ADDR_W-1:0]   wt_base,
    input  logic [CH_W-1:0]     out_ch_cnt,
    input  logic                calc_en,
    input  logic [CNT_W-1:0]    n_words,
    input  logic [CNT_W-1:0]    issue_cnt,
    output logic [ADDR_W-1:0]   mem_addr
);

    logic [ADDR_W-1:0] r_base;
    logic [CH_W-1:0]   r_ch;
    logic [OFF_W-1:0]  r_offset;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base   <= '0;
            r_ch     <= '0;
            r_offset <= '0;
        end else begin
            if (load) begin
                r_base <= wt_base;
                r_ch   <= out_ch_cnt;
            end
            // Multiply takes its own cycle so it stays off the address path
            if (calc_en) begin
                r_offset <= OFF_W'(r_ch) * OFF_W'(n_words);
            end
        end
    end

    // Sum truncates to ADDR_W, so addresses wrap at the top of memory
    assign mem_addr = r_base + ADDR_W'(r_offset) + ADDR_W'(issue_cnt);

endmodule
`default_nettype wire

// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : weight_loader
//  Description : Fetches the 3x3 kernels of the current output channel
//                (in_ch*9 words) from weight memory over a request/grant
//                read port and writes them into the local weight buffer.
//                Pulses weight_done when the last word has been written.
//  Ports       : clk, rst                  - clock, sync active-high reset
//                in_ch, out_ch_cnt, wt_base - transfer setup, sampled at start
//                weight_start / weight_done - handshake with the main FSM
//                busy                      - transfer in progress
//                mem_req/addr/gnt          - read request channel
//                mem_rvalid/rdata          - in-order read return channel
//                wbuf_we/addr/wdata        - weight buffer write port
//                chksum                    - (WLOAD_CHKSUM_EN only) 16-bit
//                                            sum of the received words
//  Options     : define WLOAD_CHKSUM_EN to add the checksum output
//  Revision    : 1.0  - initial release
// ============================================================================
module weight_loader
    import acc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BUF_AW = BUF_AW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [CH_W-1:0]     out_ch_cnt,
    input  logic [ADDR_W-1:0]   wt_base,
    input  logic                weight_start,
    output logic                weight_done,
    output logic                busy,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                wbuf_we,
    output logic [BUF_AW-1:0]   wbuf_addr,
    output logic [DATA_W-1:0]   wbuf_wdata
`ifdef WLOAD_CHKSUM_EN
    ,
    output logic [15:0]         chksum
`endif
);

    wl_state_t        r_state;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_issue_cnt;
    logic [CNT_W-1:0] r_recv_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_mem_req;

    logic             w_start;
    logic             w_gnt;
    logic             w_rx;
    logic             w_last_issue;
    logic             w_last_rx;

    assign w_start      = weight_start && (r_state == WL_IDLE);
    // Grants only count while a request is actually outstanding
    assign w_gnt        = r_mem_req && mem_gnt;
    assign w_rx         = mem_rvalid && (r_state != WL_IDLE);
    assign w_last_issue = (r_issue_cnt == r_n - CNT_W'(1));
    assign w_last_rx    = w_rx && (r_recv_cnt == r_n - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= WL_IDLE;
            r_n         <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_req   <= 1'b0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                WL_IDLE: begin
                    if (w_start) begin
                        r_n         <= word_count(in_ch);
                        r_issue_cnt <= '0;
                        r_recv_cnt  <= '0;
                        r_busy      <= 1'b1;
                        if (in_ch == '0) begin
                            r_state <= WL_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= WL_CALC;
                        end
                    end
                end

                WL_CALC: begin
                    r_state   <= WL_ISSUE;
                    r_mem_req <= 1'b1;
                end

                WL_ISSUE: begin
                    // Final grant and final return may land together
                    if (w_last_rx) begin
                        r_state   <= WL_DONE;
                        r_done    <= 1'b1;
                        r_mem_req <= 1'b0;
                    end else if (w_gnt && w_last_issue) begin
                        r_state   <= WL_DRAIN;
                        r_mem_req <= 1'b0;
                    end
                end

                WL_DRAIN: begin
                    if (w_last_rx) begin
                        r_state <= WL_DONE;
                        r_done  <= 1'b1;
                    end
                end

                WL_DONE: begin
                    r_state <= WL_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state   <= WL_IDLE;
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase

            // Grant and return paths advance independently
            if (w_gnt) begin
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            end
            if (w_rx) begin
                r_recv_cnt <= r_recv_cnt + CNT_W'(1);
            end
        end
    end

    wl_addr_gen #(
        .ADDR_W     (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (w_start),
        .wt_base    (wt_base),
        .out_ch_cnt (out_ch_cnt),
        .calc_en    (r_state == WL_CALC),
        .n_words    (r_n),
        .issue_cnt  (r_issue_cnt),
        .mem_addr   (mem_addr)
    );

    assign weight_done = r_done;
    assign busy        = r_busy;
    assign mem_req     = r_mem_req;
    assign wbuf_we     = w_rx;
    assign wbuf_addr   = BUF_AW'(r_recv_cnt);
    // Gated so the buffer write bus stays quiet outside real writes
    assign wbuf_wdata  = w_rx ? mem_rdata : '0;

`ifdef WLOAD_CHKSUM_EN
    logic [15:0] r_chksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chksum <= '0;
        end else if (w_start) begin
            r_chksum <= '0;
        end else if (w_rx) begin
            r_chksum <= r_chksum + 16'(mem_rdata);
        end
    end

    assign chksum = r_chksum;
`endif

endmodule
`default_nettype wire
